// File: rtl/control_fsm.sv
// Instruction-cycle phase sequencer: rotates fetch/decode/exec/wrbk/jmp strobes,
// each phase PHASE_LEN cycles long with a HIGH_LEN-cycle strobe at its start.
module control_fsm #(
    parameter int PHASE_LEN = 2,
    parameter int HIGH_LEN  = 1
) (
    input  logic clk,
    input  logic rst,
    output logic fetch_clk,
    output logic decode_clk,
    output logic exec_clk,
    output logic wrbk_clk,
    output logic jmp_clk
);

    localparam int CW = (PHASE_LEN <= 2) ? 1 : $clog2(PHASE_LEN);

    if (PHASE_LEN < 2) begin : g_bad_phase_len
        $error("control_fsm: PHASE_LEN must be >= 2");
    end
    if (HIGH_LEN < 1 || HIGH_LEN >= PHASE_LEN) begin : g_bad_high_len
        $error("control_fsm: HIGH_LEN must be in 1..PHASE_LEN-1");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WRBK,
        JMP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    strb_q, strb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            strb_q  <= strb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (state_q == IDLE) begin
            state_d = FETCH;
            cnt_d   = '0;
        end else if (cnt_q == CW'(PHASE_LEN - 1)) begin
            cnt_d = '0;
            unique case (state_q)
                FETCH:   state_d = DECODE;
                DECODE:  state_d = EXEC;
                EXEC:    state_d = WRBK;
                WRBK:    state_d = JMP;
                JMP:     state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are decoded from next-state so the registered outputs line up with the phase.
    always_comb begin
        strb_d = '0;
        if (cnt_d < CW'(HIGH_LEN)) begin
            unique case (state_d)
                FETCH:   strb_d[0] = 1'b1;
                DECODE:  strb_d[1] = 1'b1;
                EXEC:    strb_d[2] = 1'b1;
                WRBK:    strb_d[3] = 1'b1;
                JMP:     strb_d[4] = 1'b1;
                default: strb_d    = '0;
            endcase
        end
    end

    assign fetch_clk  = strb_q[0];
    assign decode_clk = strb_q[1];
    assign exec_clk   = strb_q[2];
    assign wrbk_clk   = strb_q[3];
    assign jmp_clk    = strb_q[4];

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: default and PHASE_LEN=4/HIGH_LEN=2 instances against a
// cycle-count reference model, with directed and random resets.
module tb_control_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic fa, da, ea, wa, ja;
    logic fb, db, eb, wb, jb;

    control_fsm u_a (
        .clk(clk), .rst(rst),
        .fetch_clk(fa), .decode_clk(da), .exec_clk(ea), .wrbk_clk(wa), .jmp_clk(ja)
    );

    control_fsm #(.PHASE_LEN(4), .HIGH_LEN(2)) u_b (
        .clk(clk), .rst(rst),
        .fetch_clk(fb), .decode_clk(db), .exec_clk(eb), .wrbk_clk(wb), .jmp_clk(jb)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, want %h", tag, $time, obs, exp);
        end
    endtask

    // Model: edges since the last reset edge; phase/offset follow from plain division.
    int t = 0;
    bit mvalid = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            t = t + 1;
        end
    end

    function automatic logic [4:0] expv(int tt, int pl, int hl);
        logic [4:0] v;
        int k;
        v = '0;
        if (tt > 0) begin
            k = tt - 1;
            if ((k % pl) < hl) v[(k / pl) % 5] = 1'b1;
        end
        return v;
    endfunction

    logic [4:0] pa = '0, pb = '0;
    always @(negedge clk) begin
        logic [4:0] va, vb;
        va = {ja, wa, ea, da, fa};
        vb = {jb, wb, eb, db, fb};
        if (mvalid) begin
            chk("strobes_a", 32'(va), 32'(expv(t, 2, 1)));
            chk("strobes_b", 32'(vb), 32'(expv(t, 4, 2)));
            chk("excl_a", 32'($countones(va) <= 1 && !(pa != 0 && va != 0 && pa != va)), 32'd1);
            chk("excl_b", 32'($countones(vb) <= 1 && !(pb != 0 && vb != 0 && pb != vb)), 32'd1);
        end
        pa = va;
        pb = vb;
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("first_fetch", 32'(fa), 32'd1);
        @(negedge clk);
        chk("fetch_fall", 32'(fa), 32'd0);
        repeat (50) @(negedge clk);

        // reset while exec strobe is high
        for (int i = 0; i < 20 && !ea; i++) @(negedge clk);
        chk("exec_seen", 32'(ea), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_zero", 32'({ja, wa, ea, da, fa, jb, wb, eb, db, fb}), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // release glitch inside the IDLE cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("idle_glitch", 32'({ja, wa, ea, da, fa, jb, wb, eb, db, fb}), 32'd0);
        rst = 1'b0;

        // random operation with sparse resets of random length
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 79) == 0) rst = 1'b1;
            else if (rst && $urandom_range(0, 1) == 0) rst = 1'b0;
        end
        rst = 1'b0;
        repeat (45) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Instruction-cycle phase sequencer for the CPU core.
- Emits five phase strobes in fixed rotation: fetch, decode, execute, write-back, jump.
- Downstream datapath blocks (instruction fetch, decoder, ALU, register write-back, PC update) use these strobes as their phase clocks/enables.
- Free-running after reset; there are no stall or handshake inputs.

Parameters:
- PHASE_LEN, 2: clock cycles each phase occupies; legal range 2..16.
- HIGH_LEN, 1: cycles the phase strobe is held high at the start of its phase; legal range 1..PHASE_LEN-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- fetch_clk  output  1  fetch-phase strobe.
- decode_clk  output  1  decode-phase strobe.
- exec_clk  output  1  execute-phase strobe.
- wrbk_clk  output  1  write-back-phase strobe.
- jmp_clk  output  1  jump/PC-update-phase strobe.

Interface: one clock; reset is synchronous and active-high (ports clk and rst).

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WRBK, JMP. Internal phase counter cnt has width clog2(PHASE_LEN), minimum 1 bit.
- Reset (rst=1 at a rising edge):
  - state <= IDLE, cnt <= 0, all five outputs <= 0.
  - Reset overrides everything, including mid-phase or mid-strobe. No output stays high past the first reset edge.
- IDLE: lasts exactly one edge. The first rising edge with rst=0 moves to FETCH with cnt=0.
- Within a phase:
  - cnt increments each edge.
  - When cnt == PHASE_LEN-1, the next edge advances the phase and clears cnt.
  - Order: FETCH -> DECODE -> EXEC -> WRBK -> JMP -> FETCH, unconditional wrap.
- Outputs are registered and glitch-free. They are decoded from the next-state values so that a strobe is high exactly while its phase is current and cnt < HIGH_LEN.
- Timing (defaults, edges counted from the first edge with rst=0 as E1):
  - fetch_clk=1 after E1, 0 after E2.
  - decode_clk=1 after E3.
  - exec_clk=1 after E5.
  - wrbk_clk=1 after E7.
  - jmp_clk=1 after E9.
  - fetch_clk=1 again after E11.
- Period: 5*PHASE_LEN cycles (10 at defaults). Each strobe is high for HIGH_LEN cycles per period.
- Mutual exclusion: at most one output is high in any cycle.
- Since HIGH_LEN < PHASE_LEN, every strobe returns low for at least one cycle before the next strobe rises. Strobes never touch or overlap.
- No output is X after the first reset edge.
- Reset released then reasserted within the IDLE cycle: outputs stay 0.
- Illegal parameters must be rejected at elaboration with an error: HIGH_LEN=0, HIGH_LEN>=PHASE_LEN, or PHASE_LEN<2.

Test Plan:
- Reset hold: rst=1 for 2 edges -> all five outputs 0; rst=0 -> fetch_clk rises on the first edge and falls on the second.
- Sequence check (defaults): run 52 cycles after reset -> rising edges of fetch/decode/exec/wrbk/jmp at cycles 1,3,5,7,9 and repeat with period 10; each pulse is 1 cycle wide.
- Exclusivity: every cycle over 500 cycles -> popcount of outputs <= 1, and no two strobes in consecutive cycles.
- Mid-operation reset: assert rst for 1 edge while exec_clk=1 -> all outputs 0 on that edge; after release fetch_clk=1 on the first edge, exec_clk does not reappear until cycle 5.
- Parameterised: PHASE_LEN=4, HIGH_LEN=2 -> each strobe high 2 cycles, low 2 cycles; period 20; decode rises 4 cycles after fetch.
